mmio_button_poller: RTL and testbench

//   Memory-mapped, N-channel push-button input controller for the bird CPU bus; replaces per-button poll units.
//   Per channel: 2-FF synchroniser, debounce counter, press detect, ready flag, 16-bit press counter, overrun flag.

---
 rtl/mmio_button_poller.sv | 124 ++++++++++++
 tb/tb_mmio_button_poller.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_button_poller.sv
// N-channel memory-mapped push-button controller: per-channel synchroniser, debouncer,
// press counter with ready/overrun flags, polled by the CPU or signalled through irq.
module mmio_button_poller #(
    parameter int N_CHAN          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit BTN_ACTIVE_LOW  = 1'b0,
    parameter int OFS_W           = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CHAN-1:0] btn_in,
    input  logic              sel,
    input  logic [OFS_W-1:0]  addr,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata,
    output logic              irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [OFS_W-1:0] OFS_STATUS   = OFS_W'(0);
    localparam logic [OFS_W-1:0] OFS_OVERRUN  = OFS_W'(1);
    localparam logic [OFS_W-1:0] OFS_IRQ_MASK = OFS_W'(2);

    logic [N_CHAN-1:0] sync_p0, sync_p1;
    logic [N_CHAN-1:0] deb, press_p2;
    logic [CNT_W-1:0]  db_cnt [N_CHAN];
    logic [N_CHAN-1:0] ready, overrun, irq_mask;
    logic [15:0]       count [N_CHAN];

    logic [N_CHAN-1:0] flip, ack, w1c;
    logic [N_CHAN-1:0] ready_next, overrun_next, mask_next;
    logic              wdata_unused;

    assign wdata_unused = ^wdata;

    // Debounced state takes the synced level once it has differed for DEBOUNCE_CYCLES samples
    always_comb begin
        flip = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            flip[i] = (sync_p1[i] != deb[i]) && (db_cnt[i] == CNT_LAST);
        end
    end

    // Stage p0/p1: synchroniser, polarity folded in so level 1 always means pressed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_in ^ {N_CHAN{BTN_ACTIVE_LOW}};
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: debounce counters; press_p2 marks a debounced 0->1 transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb      <= '0;
            press_p2 <= '0;
            for (int i = 0; i < N_CHAN; i++) db_cnt[i] <= '0;
        end else begin
            deb      <= deb ^ flip;
            press_p2 <= flip & ~deb;
            for (int i = 0; i < N_CHAN; i++) begin
                if ((sync_p1[i] == deb[i]) || flip[i]) db_cnt[i] <= '0;
                else                                   db_cnt[i] <= db_cnt[i] + 1'b1;
            end
        end
    end

    // A press on the same edge as its ack wins for ready, but the read still clears overrun
    always_comb begin
        ack = '0;
        w1c = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            ack[i] = sel && rd_en && (addr == OFS_W'(4 + i));
        end
        if (sel && wr_en && (addr == OFS_OVERRUN)) w1c = wdata[N_CHAN-1:0];
        mask_next = (sel && wr_en && (addr == OFS_IRQ_MASK)) ? wdata[N_CHAN-1:0] : irq_mask;
        ready_next   = (ready & ~ack) | press_p2;
        overrun_next = (overrun & ~w1c & ~ack) | (press_p2 & ready & ~ack);
    end

    // Stage p3: architectural registers visible on the bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready    <= '0;
            overrun  <= '0;
            irq_mask <= '0;
            irq      <= 1'b0;
            for (int i = 0; i < N_CHAN; i++) count[i] <= '0;
        end else begin
            ready    <= ready_next;
            overrun  <= overrun_next;
            irq_mask <= mask_next;
            irq      <= |(ready_next & mask_next);
            for (int i = 0; i < N_CHAN; i++) begin
                if (press_p2[i]) count[i] <= count[i] + 16'd1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            if (addr == OFS_STATUS) begin
                rdata[N_CHAN-1:0] = ready;
            end else if (addr == OFS_OVERRUN) begin
                rdata[N_CHAN-1:0] = overrun;
            end else if (addr == OFS_IRQ_MASK) begin
                rdata[N_CHAN-1:0] = irq_mask;
            end else begin
                for (int i = 0; i < N_CHAN; i++) begin
                    if (addr == OFS_W'(4 + i)) rdata = count[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_mmio_button_poller.sv
// Bench for mmio_button_poller: directed scenarios plus a random run, all checked
// against a window-based debounce model and a register-level scoreboard.
module tb_mmio_button_poller;

    localparam int N = 4;
    localparam int D = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  btn = '0;
    logic          sel = 1'b0;
    logic [4:0]    addr = '0;
    logic          rd_en = 1'b0;
    logic          wr_en = 1'b0;
    logic [15:0]   wdata = '0;
    logic [15:0]   rdata;
    logic          irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_button_poller #(
        .N_CHAN(N), .DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1'b0), .OFS_W(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn), .sel(sel), .addr(addr),
        .rd_en(rd_en), .wr_en(wr_en), .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    // Reference model: a press is due 3 edges after the D-th consecutive pressed sample
    logic [N-1:0]  m_ready, m_ovr, m_mask, m_deb;
    logic          m_irq;
    logic [15:0]   m_cnt [N];
    logic [D-1:0]  hist [N];
    int            due_q [N][$];
    int            cyc;
    logic [N-1:0]  e_evt, e_ack, e_w1c;

    task automatic model_step();
        if (!rst_n) begin
            m_ready = '0; m_ovr = '0; m_mask = '0; m_deb = '0; m_irq = 1'b0; cyc = 0;
            for (int c = 0; c < N; c++) begin
                m_cnt[c] = '0; hist[c] = '0; due_q[c].delete();
            end
        end else begin
            cyc++;
            e_w1c = (sel && wr_en && addr == 5'd1) ? wdata[N-1:0] : '0;
            for (int c = 0; c < N; c++) begin
                e_evt[c] = (due_q[c].size() > 0) && (due_q[c][0] == cyc);
                if (e_evt[c]) void'(due_q[c].pop_front());
                e_ack[c] = sel && rd_en && (addr == 5'(4 + c));
                if (e_ack[c] || e_w1c[c]) m_ovr[c] = 1'b0;
                if (e_evt[c]) begin
                    if (m_ready[c] && !e_ack[c]) m_ovr[c] = 1'b1;
                    m_ready[c] = 1'b1;
                    m_cnt[c]   = m_cnt[c] + 16'd1;
                end else if (e_ack[c]) begin
                    m_ready[c] = 1'b0;
                end
            end
            if (sel && wr_en && addr == 5'd2) m_mask = wdata[N-1:0];
            m_irq = |(m_ready & m_mask);
            for (int c = 0; c < N; c++) begin
                hist[c] = {hist[c][D-2:0], btn[c]};
                if (hist[c] == {D{~m_deb[c]}}) begin
                    m_deb[c] = ~m_deb[c];
                    if (m_deb[c]) due_q[c].push_back(cyc + 3);
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    function automatic logic [15:0] m_read(input logic s, input logic [4:0] a);
        logic [15:0] v;
        v = '0;
        if (s) begin
            if (a == 5'd0)                   v[N-1:0] = m_ready;
            else if (a == 5'd1)              v[N-1:0] = m_ovr;
            else if (a == 5'd2)              v[N-1:0] = m_mask;
            else if (a >= 5'd4 && a < 5'(4 + N)) v = m_cnt[a - 5'd4];
        end
        return v;
    endfunction

    task automatic drive(input logic s, input logic [4:0] a, input logic r,
                         input logic w, input logic [15:0] d);
        sel = s; addr = a; rd_en = r; wr_en = w; wdata = d;
    endtask

    task automatic press(input int ch, input int hold);
        btn[ch] = 1'b1;
        repeat (hold) @(negedge clk);
        btn[ch] = 1'b0;
        repeat (hold) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn = '0; drive(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); drive(1, 2, 0, 1, 16'h0001);
        @(negedge clk); drive(0, 0, 0, 0, 0); btn[0] = 1'b1;
        repeat (25) @(negedge clk);
        btn[1] = 1'b1;
        repeat (5) @(negedge clk);
        #1; checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL reset_pre_irq: got %b expected 1", irq); end
        rst_n = 1'b0; #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        drive(1, 0, 0, 0, 0); #1; checks++;
        if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_status: got %h expected 0000", rdata); end
        drive(1, 4, 0, 0, 0); #1; checks++;
        if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_count0: got %h expected 0000", rdata); end
        drive(1, 2, 0, 0, 0); #1; checks++;
        if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_mask: got %h expected 0000", rdata); end
        @(negedge clk); btn = '0; drive(0, 0, 0, 0, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_debounce();
        logic [15:0] exp;
        drive(1, 0, 0, 0, 0); btn[0] = 1'b1;
        repeat (10) @(negedge clk);
        btn[0] = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk); #1; checks++;
            if (rdata !== 16'h0000) begin errors++; $display("FAIL glitch_status: got %h expected 0000", rdata); end
        end
        btn[0] = 1'b1;
        for (int n = 1; n <= 19; n++) begin
            @(negedge clk); #1;
            exp = (n >= 19) ? 16'h0001 : 16'h0000;
            checks++;
            if (rdata !== exp) begin errors++; $display("FAIL debounce_latency edge %0d: got %h expected %h", n, rdata, exp); end
        end
        repeat (21) @(negedge clk);
        drive(1, 4, 0, 0, 0); #1; checks++;
        if (rdata !== 16'h0001) begin errors++; $display("FAIL debounce_count: got %h expected 0001", rdata); end
        btn[0] = 1'b0;
        repeat (30) @(negedge clk);
        #1; checks++;
        if (rdata !== 16'h0001) begin errors++; $display("FAIL release_count: got %h expected 0001", rdata); end
        drive(1, 0, 0, 0, 0); #1; checks++;
        if (rdata !== 16'h0001) begin errors++; $display("FAIL release_status: got %h expected 0001", rdata); end
    endtask

    task automatic test_ack();
        @(negedge clk); drive(1, 4, 1, 0, 0); #1; checks++;
        if (rdata !== 16'h0001) begin errors++; $display("FAIL ack_rdata: got %h expected 0001", rdata); end
        @(negedge clk); drive(1, 0, 0, 0, 0); #1; checks++;
        if (rdata !== 16'h0000) begin errors++; $display("FAIL ack_status: got %h expected 0000", rdata); end
        drive(1, 4, 0, 0, 0); #1; checks++;
        if (rdata !== 16'h0001) begin errors++; $display("FAIL ack_count_kept: got %h expected 0001", rdata); end
    endtask

    task automatic test_overrun();
        @(negedge clk); drive(0, 0, 0, 0, 0);
        press(2, 24);
        press(2, 24);
        drive(1, 0, 0, 0, 0); #1; checks++;
        if (rdata !== 16'h0004) begin errors++; $display("FAIL ovr_status: got %h expected 0004", rdata); end
        drive(1, 1, 0, 0, 0); #1; checks++;
        if (rdata !== 16'h0004) begin errors++; $display("FAIL ovr_flag: got %h expected 0004", rdata); end
        drive(1, 6, 0, 0, 0); #1; checks++;
        if (rdata !== 16'h0002) begin errors++; $display("FAIL ovr_count: got %h expected 0002", rdata); end
        @(negedge clk); drive(1, 1, 0, 1, 16'h0004);
        @(negedge clk); drive(1, 1, 0, 0, 0); #1; checks++;
        if (rdata !== 16'h0000) begin errors++; $display("FAIL ovr_w1c: got %h expected 0000", rdata); end
        drive(1, 0, 0, 0, 0); #1; checks++;
        if (rdata !== 16'h0004) begin errors++; $display("FAIL ovr_status_kept: got %h expected 0004", rdata); end
    endtask

    task automatic test_collision();
        @(negedge clk); drive(0, 0, 0, 0, 0);
        press(1, 24);
        press(1, 24);
        btn[1] = 1'b1;
        repeat (18) @(negedge clk);
        drive(1, 5, 1, 0, 0); #1; checks++;
        if (rdata !== 16'h0002) begin errors++; $display("FAIL coll_rdata: got %h expected 0002", rdata); end
        @(negedge clk); drive(1, 0, 0, 0, 0); #1; checks++;
        if (rdata[1] !== 1'b1) begin errors++; $display("FAIL coll_ready: got %b expected 1", rdata[1]); end
        drive(1, 5, 0, 0, 0); #1; checks++;
        if (rdata !== 16'h0003) begin errors++; $display("FAIL coll_count: got %h expected 0003", rdata); end
        drive(1, 1, 0, 0, 0); #1; checks++;
        if (rdata[1] !== 1'b0) begin errors++; $display("FAIL coll_overrun: got %b expected 0", rdata[1]); end
        btn[1] = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    task automatic test_irq();
        logic exp;
        for (int c = 0; c < N; c++) begin
            @(negedge clk); drive(1, 5'(4 + c), 1, 0, 0);
        end
        @(negedge clk); drive(1, 2, 0, 1, 16'h0002);
        @(negedge clk); drive(1, 0, 0, 0, 0); #1; checks++;
        if (rdata !== 16'h0000 || irq !== 1'b0) begin
            errors++; $display("FAIL irq_idle: got status %h irq %b expected 0000 0", rdata, irq);
        end
        drive(1, 2, 0, 0, 0); #1; checks++;
        if (rdata !== 16'h0002) begin errors++; $display("FAIL irq_mask_read: got %h expected 0002", rdata); end
        btn[0] = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk); #1; checks++;
            if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b expected 0", irq); end
        end
        btn[0] = 1'b0;
        repeat (25) @(negedge clk);
        btn[1] = 1'b1;
        for (int n = 1; n <= 19; n++) begin
            @(negedge clk); #1;
            exp = (n >= 19);
            checks++;
            if (irq !== exp) begin errors++; $display("FAIL irq_timing edge %0d: got %b expected %b", n, irq, exp); end
        end
        repeat (5) @(negedge clk);
        btn[1] = 1'b0;
        @(negedge clk); drive(1, 5, 1, 0, 0); #1; checks++;
        if (rdata !== 16'h0004) begin errors++; $display("FAIL irq_count1: got %h expected 0004", rdata); end
        @(negedge clk); drive(1, 2, 0, 1, 16'hFFFF); #1; checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_ack: got %b expected 0", irq); end
        @(negedge clk); drive(1, 2, 0, 0, 0); #1; checks++;
        if (rdata !== 16'h000F) begin errors++; $display("FAIL irq_mask_width: got %h expected 000f", rdata); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_unmask: got %b expected 1", irq); end
        @(negedge clk); drive(1, 2, 0, 1, 16'h0000);
        @(negedge clk); drive(0, 0, 0, 0, 0); #1; checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_mask_off: got %b expected 0", irq); end
    endtask

    task automatic test_random();
        int rem [N];
        logic [15:0] exp;
        for (int c = 0; c < N; c++) rem[c] = $urandom_range(1, 40);
        repeat (3000) begin
            @(negedge clk); #1;
            exp = m_read(sel, addr);
            checks++;
            if (rdata !== exp) begin errors++; $display("FAIL rnd_rdata addr %0d: got %h expected %h", addr, rdata, exp); end
            checks++;
            if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq: got %b expected %b", irq, m_irq); end
            for (int c = 0; c < N; c++) begin
                rem[c]--;
                if (rem[c] == 0) begin
                    btn[c] = ~btn[c];
                    rem[c] = $urandom_range(1, 40);
                end
            end
            drive($urandom_range(0, 9) != 0, 5'($urandom_range(0, 11)),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0), 16'($urandom));
        end
        @(negedge clk); drive(0, 0, 0, 0, 0); #1; checks++;
        if (rdata !== 16'h0000) begin errors++; $display("FAIL rnd_unselected: got %h expected 0000", rdata); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_ack();
        test_overrun();
        test_collision();
        test_irq();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
